// File: rtl/des_pkg.sv
// Shared DES constants and the final-permutation (IP^-1) source table.
// All DES vectors are numbered [1:N] with index 1 as the MSB.
package des_pkg;

    localparam int DES_BLK_W  = 64;
    localparam int DES_HALF_W = 32;
    localparam int FP_ROWS    = 8;
    localparam int FP_COLS    = 8;

    // Source bit for column c (1..8) of row 0 of the FP table.
    // Every following row takes the bit just before, so row r uses base - r.
    function automatic int fp_col_base(input int c);
        int base;
        case (c)
            1:       base = 40;
            2:       base = 8;
            3:       base = 48;
            4:       base = 16;
            5:       base = 56;
            6:       base = 24;
            7:       base = 64;
            default: base = 32;
        endcase
        return base;
    endfunction

    // Source position in the pre-output block for output position pos (1..64).
    function automatic int fp_src(input int pos);
        int r;
        int c;
        r = (pos - 1) / FP_COLS;
        c = ((pos - 1) % FP_COLS) + 1;
        return fp_col_base(c) - r;
    endfunction

endpackage

// File: rtl/fp_perm.sv
// Combinational DES final permutation (inverse of the initial permutation).
// Pure wiring: each output bit picks one pre-output bit from the table.
module fp_perm
    import des_pkg::*;
(
    input  logic [1:DES_BLK_W] in,
    output logic [1:DES_BLK_W] out
);

    // One wire per output position; the source index is an elaboration-time constant.
    for (genvar p = 1; p <= DES_BLK_W; p++) begin : g_bit
        localparam int SRC = fp_src(p);
        assign out[p] = in[SRC];
    end

endmodule

// File: rtl/des_fp_out.sv
// DES output stage: swaps L16/R16, applies the final permutation and
// buffers the result in a small FIFO toward the downstream consumer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds data stable while valid && !ready, and ready
// never depends combinationally on the same interface's valid.
module des_fp_out
    import des_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:DES_HALF_W]   l_in,
    input  logic [1:DES_HALF_W]   r_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:DES_BLK_W]    out_data,
    output logic [CNT_W-1:0]      blk_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [1:DES_BLK_W]   mem [DEPTH];
    logic [1:DES_BLK_W]   pre;
    logic [1:DES_BLK_W]   perm_data;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // 32-bit swap: R16 goes to the upper half of the pre-output block.
    assign pre = {r_in, l_in};

    fp_perm u_fp_perm (
        .in  (pre),
        .out (perm_data)
    );

    // Occupancy flags come from registered pointers only, so in_ready never
    // sees out_ready; a pop while full frees the slot one cycle later.
    always_comb begin
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty = (wr_ptr == rd_ptr);
        push  = in_valid && !full;
        pop   = out_ready && !empty;
    end

    assign in_ready  = !full;
    assign out_valid = !empty;

    // Write pointer: clear wins over any push in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // Read pointer: clear wins over any pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Delivered-block counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (clr) begin
            blk_cnt <= '0;
        end else if (pop) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end

    // Storage is plain registers without reset; stale contents are masked below.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr[AW-1:0]] <= perm_data;
        end
    end

    // Head of FIFO straight from storage, forced to zero while empty.
    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_des_fp_out.sv
// Bench for des_fp_out: directed known-answer/flow-control cases plus random
// traffic, checked by a scoreboard fed from a table-driven FP model.
module tb_des_fp_out;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:32] l_in = '0;
    logic [1:32] r_in = '0;
    logic        in_ready, out_valid;
    logic [1:64] out_data;
    logic [15:0] blk_cnt;
    logic        in_ready4, out_valid4;
    logic [1:64] out_data4;
    logic [3:0]  blk_cnt4;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_exp = '0;
    int          model_cnt = 0;
    bit          rnd_done = 0;

    // Standard DES IP^-1 table, row by row.
    int fp_tab[64] = '{40, 8, 48, 16, 56, 24, 64, 32,
                       39, 7, 47, 15, 55, 23, 63, 31,
                       38, 6, 46, 14, 54, 22, 62, 30,
                       37, 5, 45, 13, 53, 21, 61, 29,
                       36, 4, 44, 12, 52, 20, 60, 28,
                       35, 3, 43, 11, 51, 19, 59, 27,
                       34, 2, 42, 10, 50, 18, 58, 26,
                       33, 1, 41,  9, 49, 17, 57, 25};

    des_fp_out #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .l_in(l_in), .r_in(r_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .blk_cnt(blk_cnt)
    );

    des_fp_out #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready4),
        .l_in(l_in), .r_in(r_in),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .blk_cnt(blk_cnt4)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_fp(input logic [31:0] l, input logic [31:0] r);
        logic [63:0] pre;
        logic [63:0] res;
        pre = {r, l};
        res = '0;
        // DES position p (1 = MSB) lives at pre[64-p].
        for (int i = 0; i < 64; i++) res[63-i] = pre[64-fp_tab[i]];
        return res;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic [31:0] l, input logic [31:0] r, input logic [63:0] e);
        l_in     = l;
        r_in     = r;
        cur_exp  = e;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output int stalls);
        logic fire;
        stalls = 0;
        forever begin
            @(negedge clk);
            fire = in_ready;
            tick();
            if (fire) break;
            stalls++;
            if (stalls >= 64) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=%0d stalls expected=accept", stalls);
                break;
            end
        end
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r, input logic [63:0] e,
                        output int stalls);
        drive_in(l, r, e);
        wait_accept(stalls);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(output int stalls);
        logic [31:0] l;
        logic [31:0] r;
        l = $urandom();
        r = $urandom();
        send(l, r, ref_fp(l, r), stalls);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Monitor / scoreboard: decides at the falling edge what the next rising edge does.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                chk("blk_cnt", 64'(blk_cnt), 64'(model_cnt % 65536));
                chk("blk_cnt_w4", 64'(blk_cnt4), 64'(model_cnt % 16));
                chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
                chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                chk("in_ready_w4", 64'(in_ready4), 64'(exp_q.size() < DEPTH));
                chk("out_valid_w4", 64'(out_valid4), 64'(exp_q.size() != 0));
                if (clr) begin
                    exp_q.delete();
                    model_cnt = 0;
                end else begin
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL pop_empty actual=%h expected=no_block", out_data);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", out_data, e);
                            chk("out_data_w4", out_data4, e);
                            model_cnt++;
                        end
                    end
                    if (in_valid && in_ready) exp_q.push_back(cur_exp);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int st;
        int total;
        logic [63:0] a_exp;
        logic [31:0] l;
        logic [31:0] r;

        // Reset state
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        rst_n = 1'b1;
        tick();

        // Known answer
        out_ready = 1'b1;
        send(32'h43423234, 32'h0A4CD995, 64'h85E813540F0AB405, st);
        chk("kat1_valid", 64'(out_valid), 64'd1);
        chk("kat1_data", out_data, 64'h85E813540F0AB405);
        tick();
        chk("kat1_cnt", 64'(blk_cnt), 64'd1);

        // Inverse of IP(0123456789ABCDEF)
        send(32'hF0AAF0AA, 32'hCC00CCFF, 64'h0123456789ABCDEF, st);
        chk("inv_data", out_data, 64'h0123456789ABCDEF);
        tick();

        // Backpressure: A, B fill the FIFO, C stalls
        pulse_clr();
        out_ready = 1'b0;
        l = $urandom(); r = $urandom();
        a_exp = ref_fp(l, r);
        send(l, r, a_exp, st);
        chk("bp_a_stall", 64'(st), 64'd0);
        send_rand(st);
        chk("bp_b_stall", 64'(st), 64'd0);
        l = $urandom(); r = $urandom();
        drive_in(l, r, ref_fp(l, r));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_head_hold", out_data, a_exp);
        end
        out_ready = 1'b1;
        wait_accept(st);
        in_valid = 1'b0;
        chk("bp_c_stall", 64'(st), 64'd1);
        repeat (4) tick();
        chk("bp_cnt", 64'(blk_cnt), 64'd3);

        // Streaming 100 blocks with incrementing data
        pulse_clr();
        total = 0;
        for (int i = 0; i < 100; i++) begin
            l = 32'h1000_0000 + i;
            r = i;
            send(l, r, ref_fp(l, r), st);
            total += st;
        end
        chk("stream_stalls", 64'(total), 64'd0);
        chk("stream_cnt_99", 64'(blk_cnt), 64'd99);
        tick();
        chk("stream_cnt_100", 64'(blk_cnt), 64'd100);

        // Counter wrap on the 4-bit instance
        pulse_clr();
        for (int i = 0; i < 17; i++) send_rand(st);
        repeat (2) tick();
        chk("wrap_cnt4", 64'(blk_cnt4), 64'd1);
        chk("wrap_cnt16", 64'(blk_cnt), 64'd17);

        // Clear with two entries buffered while a push is pending
        out_ready = 1'b0;
        send_rand(st);
        send_rand(st);
        l = $urandom(); r = $urandom();
        drive_in(l, r, ref_fp(l, r));
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        chk("clr_blk_cnt", 64'(blk_cnt), 64'd0);
        chk("clr_in_ready", 64'(in_ready), 64'd1);
        chk("clr_out_data", out_data, 64'd0);

        // Random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send_rand(st);
                    repeat ($urandom_range(0, 2)) tick();
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) tick();

        // Asynchronous reset in the middle of a stream
        l = $urandom(); r = $urandom();
        drive_in(l, r, ref_fp(l, r));
        out_ready = 1'b0;
        repeat (2) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_blk_cnt", 64'(blk_cnt), 64'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_stale", 64'(out_valid), 64'd0);
        end

        // Recovery after reset
        for (int i = 0; i < 5; i++) send_rand(st);
        repeat (3) tick();
        chk("post_rst_cnt", 64'(blk_cnt), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
